// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one memory-controller access per load/store and
// formats the load result for MEM/WB; non-memory ops pass through unchanged.
`timescale 1ns/1ps

`ifndef ZeroOpt
`define ZeroOpt 8'h00
`endif
`ifndef LB
`define LB  8'h20
`endif
`ifndef LH
`define LH  8'h21
`endif
`ifndef LW
`define LW  8'h22
`endif
`ifndef LBU
`define LBU 8'h23
`endif
`ifndef LHU
`define LHU 8'h24
`endif
`ifndef SB
`define SB  8'h28
`endif
`ifndef SH
`define SH  8'h29
`endif
`ifndef SW
`define SW  8'h2A
`endif

module mem_stage #(
  localparam int unsigned OPT_W  = 8,
  localparam int unsigned REGA_W = 5,
  localparam int unsigned REG_W  = 32,
  localparam int unsigned ADDR_W = 32,
  localparam int unsigned LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [OPT_W-1:0]  mem_inst,
  input  logic [REGA_W-1:0] mem_rd,
  input  logic [REG_W-1:0]  mem_vd,
  input  logic              mem_w_enable,
  input  logic [ADDR_W-1:0] mem_memctrl_addr,
  output logic              memctrl_req,
  output logic              memctrl_rw,
  output logic [ADDR_W-1:0] memctrl_addr,
  output logic [LEN_W-1:0]  memctrl_len,
  output logic [REG_W-1:0]  memctrl_wdata,
  input  logic              memctrl_done,
  input  logic [REG_W-1:0]  memctrl_rdata,
  output logic [REGA_W-1:0] wb_rd,
  output logic [REG_W-1:0]  wb_vd,
  output logic              wb_w_enable,
  output logic              mem_stall_req
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [REG_W-1:0]  data_q;
  logic              is_load, is_store, is_mem;
  logic [LEN_W-1:0]  len_c;
  logic [REG_W-1:0]  load_val_c;

  // Opcode decode: access class and byte count.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    len_c    = LEN_W'(0);
    case (mem_inst)
      `LB, `LBU: begin is_load  = 1'b1; len_c = LEN_W'(1); end
      `LH, `LHU: begin is_load  = 1'b1; len_c = LEN_W'(2); end
      `LW:       begin is_load  = 1'b1; len_c = LEN_W'(4); end
      `SB:       begin is_store = 1'b1; len_c = LEN_W'(1); end
      `SH:       begin is_store = 1'b1; len_c = LEN_W'(2); end
      `SW:       begin is_store = 1'b1; len_c = LEN_W'(4); end
      default:   ;
    endcase
    is_mem = is_load | is_store;
  end

  // Sign/zero extension of the captured load data.
  always_comb begin
    load_val_c = data_q;
    case (mem_inst)
      `LB:     load_val_c = {{(REG_W-8){data_q[7]}}, data_q[7:0]};
      `LBU:    load_val_c = {{(REG_W-8){1'b0}}, data_q[7:0]};
      `LH:     load_val_c = {{(REG_W-16){data_q[15]}}, data_q[15:0]};
      `LHU:    load_val_c = {{(REG_W-16){1'b0}}, data_q[15:0]};
      default: load_val_c = data_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= REG_W'(0);
    end else if (rdy) begin
      state <= state_nxt;
      if (state == BUSY && memctrl_done) data_q <= memctrl_rdata;
    end
  end

  // Next state and outputs; memory ops keep wb_w_enable low until DONE.
  always_comb begin
    state_nxt     = state;
    memctrl_req   = 1'b0;
    mem_stall_req = 1'b0;
    memctrl_rw    = 1'b0;
    memctrl_len   = LEN_W'(0);
    memctrl_addr  = ADDR_W'(0);
    memctrl_wdata = REG_W'(0);
    wb_rd         = REGA_W'(0);
    wb_vd         = REG_W'(0);
    wb_w_enable   = 1'b0;

    if (is_mem) begin
      memctrl_rw    = is_store;
      memctrl_len   = len_c;
      memctrl_addr  = mem_memctrl_addr;
      memctrl_wdata = mem_vd;
    end

    case (state)
      IDLE: begin
        if (is_mem) begin
          memctrl_req   = 1'b1;
          mem_stall_req = 1'b1;
          state_nxt     = BUSY;
        end else begin
          wb_rd       = mem_rd;
          wb_vd       = mem_vd;
          wb_w_enable = mem_w_enable;
        end
      end
      BUSY: begin
        memctrl_req   = 1'b1;
        mem_stall_req = 1'b1;
        if (memctrl_done) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        if (is_load) begin
          wb_rd       = mem_rd;
          wb_vd       = load_val_c;
          wb_w_enable = 1'b1;
        end else if (!is_mem) begin
          wb_rd       = mem_rd;
          wb_vd       = mem_vd;
          wb_w_enable = mem_w_enable;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues expected requests and
// writebacks, a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps

`ifndef ZeroOpt
`define ZeroOpt 8'h00
`endif
`ifndef LB
`define LB  8'h20
`endif
`ifndef LH
`define LH  8'h21
`endif
`ifndef LW
`define LW  8'h22
`endif
`ifndef LBU
`define LBU 8'h23
`endif
`ifndef LHU
`define LHU 8'h24
`endif
`ifndef SB
`define SB  8'h28
`endif
`ifndef SH
`define SH  8'h29
`endif
`ifndef SW
`define SW  8'h2A
`endif

module tb_mem_stage;

  localparam logic [7:0] OP_ADD = 8'h01;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [7:0]  mem_inst;
  logic [4:0]  mem_rd;
  logic [31:0] mem_vd;
  logic        mem_w_enable;
  logic [31:0] mem_memctrl_addr;
  logic        memctrl_req, memctrl_rw;
  logic [31:0] memctrl_addr;
  logic [2:0]  memctrl_len;
  logic [31:0] memctrl_wdata;
  logic        memctrl_done;
  logic [31:0] memctrl_rdata;
  logic [4:0]  wb_rd;
  logic [31:0] wb_vd;
  logic        wb_w_enable, mem_stall_req;

  mem_stage dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_inst(mem_inst), .mem_rd(mem_rd), .mem_vd(mem_vd),
    .mem_w_enable(mem_w_enable), .mem_memctrl_addr(mem_memctrl_addr),
    .memctrl_req(memctrl_req), .memctrl_rw(memctrl_rw),
    .memctrl_addr(memctrl_addr), .memctrl_len(memctrl_len),
    .memctrl_wdata(memctrl_wdata), .memctrl_done(memctrl_done),
    .memctrl_rdata(memctrl_rdata), .wb_rd(wb_rd), .wb_vd(wb_vd),
    .wb_w_enable(wb_w_enable), .mem_stall_req(mem_stall_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] vd;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  req_t exp_req;
  wb_t  exp_wb;
  int   errors = 0;
  int   checks = 0;
  logic req_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a rising memctrl_req is one new access; wb_w_enable is one writeback.
  always @(negedge clk) begin
    if (memctrl_req && !req_prev) begin
      if (req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
      else begin
        exp_req = req_q.pop_front();
        chk("req_rw",    32'(memctrl_rw),  32'(exp_req.rw));
        chk("req_len",   32'(memctrl_len), 32'(exp_req.len));
        chk("req_addr",  memctrl_addr,     exp_req.addr);
        chk("req_wdata", memctrl_wdata,    exp_req.wdata);
      end
    end
    req_prev = memctrl_req;
    if (wb_w_enable) begin
      if (wb_q.size() == 0) chk("unexpected_wb", 32'd1, 32'd0);
      else begin
        exp_wb = wb_q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(exp_wb.rd));
        chk("wb_vd", wb_vd,      exp_wb.vd);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    mem_inst         = `ZeroOpt;
    mem_rd           = '0;
    mem_vd           = '0;
    mem_w_enable     = 1'b0;
    mem_memctrl_addr = '0;
    memctrl_done     = 1'b0;
    memctrl_rdata    = '0;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] vd, input logic we);
    mem_inst     = OP_ADD;
    mem_rd       = rd;
    mem_vd       = vd;
    mem_w_enable = we;
    if (we) wb_q.push_back('{rd: rd, vd: vd});
    @(negedge clk);
    chk("alu_stall", 32'(mem_stall_req), 32'd0);
    chk("alu_req",   32'(memctrl_req),   32'd0);
    chk("alu_we",    32'(wb_w_enable),   32'(we));
    chk("alu_vd",    wb_vd,              vd);
    step();
    set_idle();
  endtask

  // busy = number of BUSY cycles; done is pulsed in the last one.
  task automatic mem_op(input logic [7:0] op, input logic [4:0] rd, input logic [31:0] vd,
                        input logic [31:0] addr, input int busy, input logic [31:0] rdata,
                        input logic is_load, input logic rw, input logic [2:0] len,
                        input logic [31:0] exp_vd);
    int stalls;
    mem_inst         = op;
    mem_rd           = rd;
    mem_vd           = vd;
    mem_w_enable     = is_load;
    mem_memctrl_addr = addr;
    req_q.push_back('{rw: rw, len: len, addr: addr, wdata: vd});
    if (is_load) wb_q.push_back('{rd: rd, vd: exp_vd});
    stalls = 0;
    for (int i = 0; i <= busy; i++) begin
      memctrl_done  = (i == busy) && (i > 0);
      memctrl_rdata = rdata;
      @(negedge clk);
      if (mem_stall_req) stalls++;
      if (!is_load) chk("store_no_wb", 32'(wb_w_enable), 32'd0);
      step();
    end
    memctrl_done = 1'b0;
    @(negedge clk);
    chk("done_stall",   32'(mem_stall_req), 32'd0);
    chk("done_req",     32'(memctrl_req),   32'd0);
    chk("done_we",      32'(wb_w_enable),   32'(is_load));
    if (!is_load) chk("store_wb_rd", 32'(wb_rd), 32'd0);
    chk("stall_cycles", 32'(stalls), 32'(busy + 1));
    step();
    set_idle();
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   32'(memctrl_req),   32'd0);
    chk("rst_stall", 32'(mem_stall_req), 32'd0);
    chk("rst_we",    32'(wb_w_enable),   32'd0);
    chk("rst_vd",    wb_vd,              32'd0);
    chk("rst_len",   32'(memctrl_len),   32'd0);
    step();
    rst = 1'b0;

    alu_op(5'd5, 32'h0000_1234, 1'b1);
    alu_op(5'd7, 32'h0000_AAAA, 1'b0);

    mem_op(`LB,  5'd3, 32'h0, 32'h100, 3, 32'h0000_0080, 1'b1, 1'b0, 3'd1, 32'hFFFF_FF80);
    mem_op(`LHU, 5'd4, 32'h0, 32'h104, 1, 32'h0000_8001, 1'b1, 1'b0, 3'd2, 32'h0000_8001);
    mem_op(`LW,  5'd6, 32'h0, 32'h108, 2, 32'hDEAD_BEEF, 1'b1, 1'b0, 3'd4, 32'hDEAD_BEEF);
    mem_op(`LH,  5'd8, 32'h0, 32'h10C, 1, 32'h1234_8001, 1'b1, 1'b0, 3'd2, 32'hFFFF_8001);
    mem_op(`LBU, 5'd9, 32'h0, 32'h110, 1, 32'h0000_00F0, 1'b1, 1'b0, 3'd1, 32'h0000_00F0);
    mem_op(`SW,  5'd10, 32'hCAFE_BABE, 32'h20, 2, 32'h0, 1'b0, 1'b1, 3'd4, 32'h0);
    mem_op(`SB,  5'd11, 32'h0011_2233, 32'h21, 1, 32'h0, 1'b0, 1'b1, 3'd1, 32'h0);
    mem_op(`SH,  5'd12, 32'h0000_BEEF, 32'h22, 1, 32'h0, 1'b0, 1'b1, 3'd2, 32'h0);
    mem_op(`LW,  5'd13, 32'h0, 32'h24, 1, 32'h0000_0007, 1'b1, 1'b0, 3'd4, 32'h0000_0007);

    // Reset while BUSY: request drops, later done is ignored.
    mem_inst = `LB; mem_rd = 5'd2; mem_w_enable = 1'b1; mem_memctrl_addr = 32'h40;
    req_q.push_back('{rw: 1'b0, len: 3'd1, addr: 32'h40, wdata: 32'h0});
    @(negedge clk);
    step();
    @(negedge clk);
    chk("busy_req", 32'(memctrl_req), 32'd1);
    step();
    rst = 1'b1;
    set_idle();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req",   32'(memctrl_req),   32'd0);
    chk("post_rst_stall", 32'(mem_stall_req), 32'd0);
    step();
    memctrl_done = 1'b1; memctrl_rdata = 32'h55;
    @(negedge clk);
    chk("late_done_we", 32'(wb_w_enable), 32'd0);
    step();
    memctrl_done = 1'b0;
    @(negedge clk);
    chk("late_done_req", 32'(memctrl_req), 32'd0);
    chk("late_done_we2", 32'(wb_w_enable), 32'd0);
    step();

    // rdy low in BUSY: state and request hold, a done while stalled is lost.
    mem_inst = `LW; mem_rd = 5'd14; mem_w_enable = 1'b1; mem_memctrl_addr = 32'h80;
    req_q.push_back('{rw: 1'b0, len: 3'd4, addr: 32'h80, wdata: 32'h0});
    wb_q.push_back('{rd: 5'd14, vd: 32'h0102_0304});
    @(negedge clk);
    step();
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      memctrl_done  = (i == 1);
      memctrl_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("rdy_low_req",   32'(memctrl_req),   32'd1);
      chk("rdy_low_stall", 32'(mem_stall_req), 32'd1);
      step();
    end
    rdy = 1'b1;
    memctrl_done = 1'b0;
    @(negedge clk);
    chk("rdy_back_req", 32'(memctrl_req), 32'd1);
    step();
    memctrl_done = 1'b1; memctrl_rdata = 32'h0102_0304;
    @(negedge clk);
    chk("rdy_busy_we", 32'(wb_w_enable), 32'd0);
    step();
    memctrl_done = 1'b0;
    @(negedge clk);
    chk("rdy_done_we",  32'(wb_w_enable), 32'd1);
    chk("rdy_done_req", 32'(memctrl_req), 32'd0);
    step();
    set_idle();

    alu_op(5'd1, 32'h0BAD_F00D, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("wb_q_empty",  32'(wb_q.size()),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: none; opcode values are the team `LB/`LH/`LW/`LBU/`LHU/`SB/`SH/`SW macros; any other mem_inst value is a non-memory opcode.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, named as the codebase does (clk, rst), plus rdy as a global enable.
REQ-003 clk  in  1  clock, all state updates on posedge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 rdy  in  1  global enable; when low, all state holds.
REQ-006 mem_inst  in  OptBus  opcode from EX/MEM register.
REQ-007 mem_rd  in  RegAddrBus  destination register.
REQ-008 mem_vd  in  RegBus  ALU result (non-memory ops) or store data (stores).
REQ-009 mem_w_enable  in  1  register write enable from EX.
REQ-010 mem_memctrl_addr  in  AddrBus  effective address for loads and stores.
REQ-011 memctrl_req  out  1  access request, level, held until memctrl_done.
REQ-012 memctrl_rw  out  1  1 = write, 0 = read.
REQ-013 memctrl_addr  out  AddrBus  access address.
REQ-014 memctrl_len  out  3  byte count, 1, 2 or 4.
REQ-015 memctrl_wdata  out  RegBus  store data, low memctrl_len bytes significant.
REQ-016 memctrl_done  in  1  one-cycle completion pulse from memory controller.
REQ-017 memctrl_rdata  in  RegBus  load data, valid with memctrl_done, low bytes significant.
REQ-018 wb_rd  out  RegAddrBus  destination to MEM/WB.
REQ-019 wb_vd  out  RegBus  writeback value to MEM/WB.
REQ-020 wb_w_enable  out  1  writeback enable to MEM/WB.
REQ-021 mem_stall_req  out  1  request to stall controller to hold IF..MEM (drives stall_ctrler bit 3 source).

Function
REQ-022 FSM states: IDLE, BUSY, DONE, held in a registered state variable.
REQ-023 IDLE with memory opcode: assert memctrl_req combinationally, mem_stall_req=1, next state BUSY.
REQ-024 IDLE with non-memory opcode: wb_rd=mem_rd, wb_vd=mem_vd, wb_w_enable=mem_w_enable, mem_stall_req=0, zero added latency.
REQ-025 BUSY: memctrl_req=1, mem_stall_req=1, request fields stable; on memctrl_done, capture memctrl_rdata into a data register, next state DONE.
REQ-026 DONE: memctrl_req=0, mem_stall_req=0, wb outputs driven from the captured data; next state IDLE unconditionally.
REQ-027 Exactly one memctrl access SHALL be issued per memory instruction, even though EX/MEM holds that instruction through DONE.
REQ-028 memctrl_len: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW; memctrl_rw=1 only for SB/SH/SW.
REQ-029 memctrl_addr=mem_memctrl_addr; memctrl_wdata=mem_vd.
REQ-030 Load result: LB sign-extends bit 7, LH sign-extends bit 15, LBU/LHU zero-extend, LW passes 32 bits.
REQ-031 Stores SHALL force wb_w_enable=0 and wb_rd=0; loads SHALL force wb_w_enable=1 with wb_rd=mem_rd.
REQ-032 Outside DONE, memory opcodes SHALL drive wb_w_enable=0, so the MEM/WB register never captures a partial result.
REQ-033 A memctrl_done arriving in IDLE or DONE SHALL be ignored.
REQ-034 rdy low: state and data register hold; memctrl_req keeps its current value; a memctrl_done pulse during rdy low is lost, so the memory controller SHALL share rdy.
REQ-035 Minimum latency of a memory instruction: 1 cycle IDLE + 1 or more cycles BUSY + 1 cycle DONE; back-to-back memory instructions re-enter BUSY from IDLE.

Reset
REQ-036 rst SHALL force state=IDLE and data register=0; with the `ZeroOpt opcode present, all outputs read 0.
REQ-037 rst during BUSY SHALL drop memctrl_req on the following cycle; a later memctrl_done SHALL be ignored.

Verification
REQ-038 ADD-class op, mem_rd=5, mem_vd=0x1234, w_enable=1 -> same cycle wb_rd=5, wb_vd=0x1234, wb_w_enable=1, stall_req=0, memctrl_req=0.
REQ-039 LB addr=0x100, rdata=0x80 after 3 BUSY cycles -> memctrl_len=1, rw=0, stall_req high 4 cycles, DONE wb_vd=0xFFFFFF80, wb_w_enable=1.
REQ-040 LHU, rdata=0x8001 -> wb_vd=0x00008001; LW, rdata=0xDEADBEEF -> wb_vd=0xDEADBEEF.
REQ-041 SW addr=0x20, vd=0xCAFEBABE -> rw=1, len=4, wdata=0xCAFEBABE, one request only, wb_w_enable=0 throughout.
REQ-042 rst asserted in BUSY, then memctrl_done pulse -> state IDLE, memctrl_req=0 next cycle, no wb_w_enable pulse.
REQ-043 rdy low for 2 cycles while in BUSY, with no done -> state held, req held; done after rdy returns -> normal DONE.
